// File: rtl/mem_responder_if.sv
// Initiator-side memory bus plus the TX byte stream of the memory-mapped responder.
// The master side drives address, write data, strobe and tx_ready; the slave answers.
interface mem_responder_if #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8
);
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [MEM_DATA_WIDTH-1:0] mem_data_i;
  logic                      mem_WE;
  logic [MEM_DATA_WIDTH-1:0] mem_data_o;
  logic [7:0]                tx_data;
  logic                      tx_valid;
  logic                      tx_ready;

  modport master (
    output mem_addr, mem_data_i, mem_WE, tx_ready,
    input  mem_data_o, tx_data, tx_valid
  );

  modport slave (
    input  mem_addr, mem_data_i, mem_WE, tx_ready,
    output mem_data_o, tx_data, tx_valid
  );
endinterface

// File: rtl/mem_responder.sv
// Memory-mapped responder: 240-byte RAM, GPIO, TX FIFO and a reloading down-counter timer.
// Reads are combinational from the current state; writes land on the rising clock edge.
module mem_responder #(
  parameter int MEM_ADDR_WIDTH = 8,
  parameter int MEM_DATA_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic           clk,
  input  logic           arst,
  mem_responder_if.slave bus,
  input  logic [7:0]     gpio_in,
  output logic [7:0]     gpio_out,
  output logic           timer_irq
);
  localparam int RAM_WORDS = 240;
  localparam int PTR_W     = $clog2(FIFO_DEPTH);
  localparam int CNT_W     = PTR_W + 1;

  localparam logic [MEM_ADDR_WIDTH-1:0] A_GPIO_OUT = MEM_ADDR_WIDTH'(8'hF0);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_GPIO_IN  = MEM_ADDR_WIDTH'(8'hF1);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_TX_DATA  = MEM_ADDR_WIDTH'(8'hF2);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_STATUS   = MEM_ADDR_WIDTH'(8'hF3);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_RELOAD   = MEM_ADDR_WIDTH'(8'hF4);
  localparam logic [MEM_ADDR_WIDTH-1:0] A_CTRL     = MEM_ADDR_WIDTH'(8'hF5);

  logic [MEM_DATA_WIDTH-1:0] ram [RAM_WORDS];
  logic [7:0]                fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]          wr_ptr, rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [7:0]                gpio_sync_p0, gpio_sync_p1;
  logic [7:0]                reload, cnt;
  logic                      timer_en, expired, overflow;

  logic [7:0] wdata;
  logic       is_ram;
  logic       wr_ram, wr_gpio, wr_tx, wr_status, wr_reload, wr_ctrl;
  logic       fifo_full, fifo_empty, pop, push, fifo_drop;
  logic       en_rise, expire, clr_expired, clr_overflow;
  logic [MEM_DATA_WIDTH-1:0] rdata;

  assign wdata     = bus.mem_data_i[7:0];
  assign is_ram    = (bus.mem_addr < A_GPIO_OUT);
  assign wr_ram    = bus.mem_WE && is_ram;
  assign wr_gpio   = bus.mem_WE && (bus.mem_addr == A_GPIO_OUT);
  assign wr_tx     = bus.mem_WE && (bus.mem_addr == A_TX_DATA);
  assign wr_status = bus.mem_WE && (bus.mem_addr == A_STATUS);
  assign wr_reload = bus.mem_WE && (bus.mem_addr == A_RELOAD);
  assign wr_ctrl   = bus.mem_WE && (bus.mem_addr == A_CTRL);

  // A push into a full FIFO still fits when the head leaves on the same edge.
  assign fifo_full  = (count == CNT_W'(FIFO_DEPTH));
  assign fifo_empty = (count == '0);
  assign pop        = !fifo_empty && bus.tx_ready;
  assign push       = wr_tx && (!fifo_full || pop);
  assign fifo_drop  = wr_tx && !push;

  assign en_rise      = wr_ctrl && wdata[0] && !timer_en;
  assign expire       = timer_en && (cnt == 8'd0);
  assign clr_expired  = wr_status && wdata[2];
  assign clr_overflow = wr_status && wdata[3];

  assign bus.tx_valid = !fifo_empty;
  assign bus.tx_data  = fifo_empty ? 8'h00 : fifo_mem[rd_ptr];
  assign timer_irq    = expired;

  always_ff @(posedge clk) begin
    if (wr_ram) ram[bus.mem_addr] <= bus.mem_data_i;
    if (push)   fifo_mem[wr_ptr]  <= wdata;
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  // gpio_in stage boundaries: p0 catches the asynchronous pins, p1 is the settled copy
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      gpio_sync_p0 <= '0;
      gpio_sync_p1 <= '0;
    end else begin
      gpio_sync_p0 <= gpio_in;
      gpio_sync_p1 <= gpio_sync_p0;
    end
  end

  // Sticky bits: a set on the same edge as a write-one-to-clear wins.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      gpio_out <= '0;
      reload   <= '0;
      timer_en <= 1'b0;
      cnt      <= '0;
      expired  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (wr_gpio)   gpio_out <= wdata;
      if (wr_reload) reload   <= wdata;
      if (wr_ctrl)   timer_en <= wdata[0];
      if (en_rise)       cnt <= reload;
      else if (timer_en) cnt <= (cnt == 8'd0) ? reload : cnt - 8'd1;
      expired  <= (expired  && !clr_expired)  || expire;
      overflow <= (overflow && !clr_overflow) || fifo_drop;
    end
  end

  always_comb begin
    rdata = '0;
    if (is_ram) begin
      rdata = ram[bus.mem_addr];
    end else begin
      case (bus.mem_addr)
        A_GPIO_OUT: rdata = MEM_DATA_WIDTH'(gpio_out);
        A_GPIO_IN:  rdata = MEM_DATA_WIDTH'(gpio_sync_p1);
        A_STATUS:   rdata = MEM_DATA_WIDTH'({4'b0000, overflow, expired, fifo_empty, fifo_full});
        A_RELOAD:   rdata = MEM_DATA_WIDTH'(reload);
        A_CTRL:     rdata = MEM_DATA_WIDTH'({7'b0000000, timer_en});
        default:    rdata = '0;
      endcase
    end
  end

  assign bus.mem_data_o = rdata;
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: a driver feeds bus cycles and a spec-level model; a monitor
// pops per-cycle expectations and the expected TX byte order and compares the DUT.
module tb_mem_responder;
  localparam int DEPTH = 4;

  logic       clk  = 1'b0;
  logic       arst = 1'b0;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out;
  logic       timer_irq;

  mem_responder_if #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(8)) bus ();

  mem_responder #(.MEM_ADDR_WIDTH(8), .MEM_DATA_WIDTH(8), .FIFO_DEPTH(DEPTH)) dut (
    .clk      (clk),
    .arst     (arst),
    .bus      (bus),
    .gpio_in  (gpio_in),
    .gpio_out (gpio_out),
    .timer_irq(timer_irq)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] addr;
    logic       rd_known;
    logic [7:0] rd;
    logic       irq;
    logic [7:0] gout;
    logic       tv;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] tx_exp_q[$];

  // Reference model state
  logic [7:0] ram_m [240];
  bit         ram_known [240];
  logic [7:0] gout_m, reload_m;
  bit         en_m, expired_m, overflow_m;
  int         next_exp, cyc;
  logic [7:0] fifo_m[$];
  logic [7:0] gpio_hist[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h expected=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    gout_m = 8'h00; reload_m = 8'h00;
    en_m = 0; expired_m = 0; overflow_m = 0;
    next_exp = 0; cyc = 0;
    fifo_m.delete();
    tx_exp_q.delete();
    gpio_hist.delete();
    gpio_hist.push_back(8'h00);
    gpio_hist.push_back(8'h00);
    for (int i = 0; i < 240; i++) ram_known[i] = 0;
  endtask

  function automatic logic [7:0] status_m();
    return {4'b0000, overflow_m, expired_m, fifo_m.size() == 0, fifo_m.size() == DEPTH};
  endfunction

  // One bus cycle: called at posedge+1, drives inputs, records expectations, models the edge.
  task automatic op(input logic [7:0] a, input bit we, input logic [7:0] d,
                    input bit rdy, input logic [7:0] g);
    exp_t e;
    bit   pop, expire, is_tx, push_ok;
    bus.mem_addr = a; bus.mem_WE = we; bus.mem_data_i = d; bus.tx_ready = rdy; gpio_in = g;
    e.addr = a; e.rd_known = 1'b1; e.rd = 8'h00;
    if (a < 8'hF0) begin
      e.rd_known = ram_known[a];
      e.rd       = ram_m[a];
    end else begin
      case (a)
        8'hF0:   e.rd = gout_m;
        8'hF1:   e.rd = gpio_hist[gpio_hist.size() - 2];
        8'hF3:   e.rd = status_m();
        8'hF4:   e.rd = reload_m;
        8'hF5:   e.rd = {7'b0000000, en_m};
        default: e.rd = 8'h00;
      endcase
    end
    e.irq  = expired_m;
    e.gout = gout_m;
    e.tv   = (fifo_m.size() > 0);
    exp_q.push_back(e);

    pop     = (fifo_m.size() > 0) && rdy;
    expire  = en_m && (cyc == next_exp);
    is_tx   = we && (a == 8'hF2);
    push_ok = is_tx && ((fifo_m.size() < DEPTH) || pop);
    if (pop) void'(fifo_m.pop_front());
    if (push_ok) begin
      fifo_m.push_back(d);
      tx_exp_q.push_back(d);
    end
    expired_m  = (expired_m  && !(we && a == 8'hF3 && d[2])) || expire;
    overflow_m = (overflow_m && !(we && a == 8'hF3 && d[3])) || (is_tx && !push_ok);
    if (expire) next_exp = cyc + int'(reload_m) + 1;
    if (we && a == 8'hF5) begin
      if (d[0] && !en_m) next_exp = cyc + int'(reload_m) + 1;
      en_m = d[0];
    end
    if (we && a == 8'hF4) reload_m = d;
    if (we && a == 8'hF0) gout_m = d;
    if (we && a < 8'hF0) begin
      ram_m[a]     = d;
      ram_known[a] = 1;
    end
    gpio_hist.push_back(g);
    if (gpio_hist.size() > 3) void'(gpio_hist.pop_front());
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset_midrun();
    bus.mem_WE = 1'b0; bus.tx_ready = 1'b0;
    @(negedge clk);
    #2;
    arst = 1'b1;
    #1;
    check("rst_tx_valid", bus.tx_valid, 0);
    check("rst_tx_data", bus.tx_data, 8'h00);
    check("rst_gpio_out", gpio_out, 8'h00);
    check("rst_timer_irq", timer_irq, 0);
    bus.mem_addr = 8'hF0; bus.mem_data_i = 8'hFF; bus.mem_WE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    bus.mem_WE = 1'b0;
    arst = 1'b0;
    model_reset();
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (e.rd_known) check($sformatf("rd_%02h", e.addr), bus.mem_data_o, e.rd);
      check("timer_irq", timer_irq, e.irq);
      check("gpio_out", gpio_out, e.gout);
      check("tx_valid", bus.tx_valid, e.tv);
    end
    if (bus.tx_valid && bus.tx_ready) begin
      if (tx_exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL tx_unexpected actual=0x%0h expected=none at %0t", bus.tx_data, $time);
      end else begin
        check("tx_data", bus.tx_data, tx_exp_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "bench did not complete");
  end

  initial begin
    logic [7:0] a, d, g;
    bit         we, rdy;
    int         sel;
    bus.mem_addr = 8'h00; bus.mem_WE = 1'b0; bus.mem_data_i = 8'h00;
    bus.tx_ready = 1'b0; gpio_in = 8'h00;

    #2 arst = 1'b1;
    #1;
    check("init_tx_valid", bus.tx_valid, 0);
    check("init_tx_data", bus.tx_data, 8'h00);
    check("init_gpio_out", gpio_out, 8'h00);
    check("init_timer_irq", timer_irq, 0);
    bus.mem_addr = 8'hF3;
    #1 check("init_status", bus.mem_data_o, 8'h02);
    bus.mem_addr = 8'hF5;
    #1 check("init_ctrl", bus.mem_data_o, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    model_reset();

    // RAM and unmapped space, including a same-cycle read of a written word
    op(8'h10, 1, 8'h5A, 0, 0);
    op(8'h10, 0, 8'h00, 0, 0);
    op(8'hF8, 0, 8'h00, 0, 0);
    op(8'hF9, 1, 8'h33, 0, 0);
    op(8'hF9, 0, 8'h00, 0, 0);
    op(8'h10, 1, 8'h77, 0, 0);
    op(8'h10, 0, 8'h00, 0, 0);
    op(8'hEF, 1, 8'hE5, 0, 0);
    op(8'hEF, 0, 8'h00, 0, 0);

    // Fill past full, then drain
    for (int i = 1; i <= 5; i++) op(8'hF2, 1, 8'(i), 0, 0);
    op(8'hF3, 0, 8'h00, 0, 0);
    repeat (6) op(8'hF3, 0, 8'h00, 1, 0);
    op(8'hF3, 1, 8'h08, 0, 0);
    op(8'hF3, 0, 8'h00, 0, 0);

    // Push while full with a pop on the same edge
    for (int i = 0; i < 4; i++) op(8'hF2, 1, 8'hB0 + 8'(i), 0, 0);
    op(8'hF2, 1, 8'hAA, 1, 0);
    op(8'hF3, 0, 8'h00, 0, 0);
    repeat (6) op(8'hF3, 0, 8'h00, 1, 0);

    // Timer: period 4, clears, clear colliding with expiry, RELOAD change while running
    op(8'hF4, 1, 8'h03, 0, 0);
    op(8'hF5, 1, 8'h01, 0, 0);
    repeat (10) op(8'hF3, 0, 8'h00, 0, 0);
    op(8'hF3, 1, 8'h04, 0, 0);
    op(8'hF3, 0, 8'h00, 0, 0);
    repeat (5) op(8'hF3, 1, 8'h04, 0, 0);
    op(8'hF4, 1, 8'h00, 0, 0);
    repeat (8) op(8'hF3, 0, 8'h00, 0, 0);
    repeat (3) op(8'hF3, 1, 8'h04, 0, 0);
    op(8'hF4, 1, 8'h02, 0, 0);
    repeat (8) op(8'hF3, 0, 8'h00, 0, 0);
    op(8'hF5, 1, 8'h00, 0, 0);
    op(8'hF3, 1, 8'h04, 0, 0);
    repeat (3) op(8'hF3, 0, 8'h00, 0, 0);

    // GPIO in/out
    repeat (4) op(8'hF1, 0, 8'h00, 0, 8'hC3);
    op(8'hF0, 1, 8'h81, 0, 8'h3C);
    op(8'hF1, 0, 8'h00, 0, 8'h3C);
    op(8'hF0, 0, 8'h00, 0, 8'h3C);
    op(8'hF1, 0, 8'h00, 0, 8'h3C);

    // Randomised traffic over the whole map
    repeat (2000) begin
      sel = int'($urandom_range(0, 9));
      if (sel < 3)       a = 8'($urandom_range(0, 15));
      else if (sel == 3) a = 8'($urandom_range(224, 239));
      else               a = 8'(8'hF0 + 8'($urandom_range(0, 15)));
      we  = ($urandom_range(0, 1) == 1);
      d   = 8'($urandom);
      if (a == 8'hF4) d = d & 8'h07;
      rdy = ($urandom_range(0, 2) != 0);
      g   = 8'($urandom);
      op(a, we, d, rdy, g);
    end

    // Reset mid-run with FIFO holding data and the timer flagging
    op(8'hF0, 1, 8'h5F, 0, 0);
    op(8'hF4, 1, 8'h01, 0, 0);
    op(8'hF5, 1, 8'h00, 0, 0);
    op(8'hF5, 1, 8'h01, 0, 0);
    for (int i = 0; i < 3; i++) op(8'hF2, 1, 8'hC0 + 8'(i), 0, 0);
    repeat (3) op(8'hF3, 0, 8'h00, 0, 0);
    do_reset_midrun();
    op(8'hF3, 0, 8'h00, 0, 0);
    op(8'hF0, 0, 8'h00, 0, 0);
    op(8'hF5, 0, 8'h00, 0, 0);
    repeat (3) op(8'hF3, 0, 8'h00, 1, 0);

    // Final traffic and drain
    for (int i = 0; i < 3; i++) op(8'hF2, 1, 8'hD0 + 8'(i), 0, 0);
    repeat (8) op(8'hF3, 0, 8'h00, 1, 0);
    check("tx_drained", tx_exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_ADDR_WIDTH, 8, data-bus address width; the block SHALL support exactly 8.
REQ-002 Parameter MEM_DATA_WIDTH, 8, data word width.
REQ-003 Parameter FIFO_DEPTH, 4, TX FIFO entries; power of two, 2..16.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 arst  input  1  asynchronous, active-high reset.
REQ-006 mem_addr  input  MEM_ADDR_WIDTH  address from the instruction-cycle initiator (its MAR).
REQ-007 mem_data_i  input  MEM_DATA_WIDTH  write data from the initiator (its MBR_o).
REQ-008 mem_WE  input  1  write strobe, one cycle wide.
REQ-009 mem_data_o  output  MEM_DATA_WIDTH  read data returned to the initiator.
REQ-010 gpio_in  input  8  external asynchronous inputs.
REQ-011 gpio_out  output  8  registered GPIO output.
REQ-012 tx_data  output  8  head of the TX FIFO.
REQ-013 tx_valid  output  1  TX FIFO not empty.
REQ-014 tx_ready  input  1  downstream accepts tx_data.
REQ-015 timer_irq  output  1  copy of the sticky EXPIRED bit.

Function
REQ-016 Address map:
- 0x00-0xEF: RAM, 240 bytes.
- 0xF0: GPIO_OUT, R/W.
- 0xF1: GPIO_IN, read-only.
- 0xF2: TX_DATA, write pushes the FIFO; reads return 0.
- 0xF3: STATUS, R/W1C.
- 0xF4: RELOAD, R/W.
- 0xF5: CTRL, R/W; only bit0 (timer enable) is implemented, other bits read 0.
- 0xF6-0xFF: reads return 0; writes are ignored.
REQ-017 Read path: mem_data_o SHALL be purely combinational from mem_addr and current register/RAM state (zero-cycle latency). The initiator samples it one edge after it loads MAR.
REQ-018 Write path: when mem_WE=1 at a rising edge, the addressed location SHALL take mem_data_i at that edge. When mem_WE=0, no state changes through the bus.
REQ-019 A read of an address in the same cycle it is written SHALL return the old value. The new value appears in the following cycle.
REQ-020 GPIO_IN SHALL read gpio_in through a two-flop synchronizer, giving 2 cycles of latency.
REQ-021 STATUS bits:
- bit0: FIFO full.
- bit1: FIFO empty.
- bit2: EXPIRED, sticky.
- bit3: OVERFLOW, sticky.
- bits7:4: read 0.
- Writing 1 to bit2 or bit3 clears that bit; writing 0 has no effect; bits 0-1 ignore writes.
REQ-022 TX FIFO push: a write to 0xF2 SHALL be accepted if count<FIFO_DEPTH, or if a pop occurs in the same cycle. Otherwise the data is dropped and OVERFLOW is set.
REQ-023 TX FIFO pop occurs when tx_valid && tx_ready at a rising edge. tx_data SHALL equal the oldest entry, and is held stable while tx_valid=1 and tx_ready=0.
REQ-024 Simultaneous push and pop SHALL leave count unchanged. Read and write pointers wrap modulo FIFO_DEPTH.
REQ-025 Timer: 8-bit down-counter CNT.
- Writing CTRL.bit0 from 0 to 1 loads CNT=RELOAD.
- While enabled, CNT decrements by 1 each cycle.
- When CNT=0 at an edge: CNT reloads from RELOAD and EXPIRED sets. The period is RELOAD+1 cycles.
- While disabled, CNT holds its value.
REQ-026 RELOAD=0 with the timer enabled SHALL set EXPIRED every cycle.
REQ-027 If EXPIRED (or OVERFLOW) is cleared in the same cycle it is set, the set SHALL win.
REQ-028 A write to RELOAD while enabled SHALL take effect at the next reload only; CNT is not changed.

Reset
REQ-029 While arst=1, regardless of clk, the following SHALL be forced:
- GPIO_OUT=0, RELOAD=0, CTRL=0, CNT=0.
- STATUS sticky bits=0.
- FIFO pointers and count=0, so tx_valid=0 and tx_data=0.
- Synchronizer flops=0; timer_irq=0.
REQ-030 RAM contents SHALL NOT be reset; their value after reset is undefined.
REQ-031 Reset mid-transfer SHALL discard all FIFO contents. A pending mem_WE in the same cycle as reset is ignored.

Verification
REQ-032 Write 0x5A to 0x10, next cycle read 0x10 -> mem_data_o=0x5A. Read 0xF8 -> 0x00. Write 0x33 to 0xF9, then read 0xF9 -> 0x00.
REQ-033 With tx_ready=0, push 0x01..0x05 -> STATUS=0x09 (full plus overflow). Then set tx_ready=1 -> tx_data is 0x01,0x02,0x03,0x04 on consecutive cycles, then tx_valid=0 and STATUS=0x0A.
REQ-034 FIFO full with tx_ready=1, push 0xAA in the same cycle as a pop -> accepted, OVERFLOW stays 0, count stays 4.
REQ-035 RELOAD=3, CTRL=1 -> EXPIRED and timer_irq rise 4 cycles after enable and repeat every 4 cycles. Write STATUS=0x04 -> cleared. A clear coinciding with an expiry -> remains 1.
REQ-036 gpio_in=0xC3 -> GPIO_IN reads 0xC3 two cycles later. Write GPIO_OUT=0x81 -> gpio_out=0x81 the next cycle.
REQ-037 Assert arst mid-run with FIFO non-empty and timer enabled -> immediately tx_valid=0, gpio_out=0, timer_irq=0. After release, STATUS reads 0x02.
